// File: rtl/uart_pkg.sv
// Shared encodings and state types for the UART responder.
// Imported by the top and by the RX deserialiser.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;

  localparam logic RORS_SEND = 1'b1;
  localparam logic RORS_RECV = 1'b0;

  typedef enum logic [2:0] {
    C_IDLE,
    C_TX_BIT,
    C_TX_DONE,
    C_RX_WAIT,
    C_RX_DONE
  } ctl_state_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_START,
    D_DATA,
    D_STOP,
    D_WAIT_HI
  } deser_state_t;

endpackage

// File: rtl/uart_rx_deser.sv
// Free-running 8N1 receiver: 2-FF synchroniser, bit-centre sampling,
// start-glitch rejection and stop-bit framing check.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  deser_state_t  r_state;
  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= D_IDLE;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_s1    <= rxd;
      r_s2    <= r_s1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        D_IDLE: begin
          if (!r_s2) begin
            r_cnt   <= '0;
            r_state <= D_START;
          end
        end
        // Re-check half a bit later so a short glitch is not a start bit
        D_START: begin
          if (r_cnt == HALF_END) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_s2 ? D_IDLE : D_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        D_DATA: begin
          if (r_cnt == BIT_END) begin
            r_cnt   <= '0;
            r_shift <= {r_s2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= D_STOP;
            else r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        D_STOP: begin
          if (r_cnt == BIT_END) begin
            r_cnt <= '0;
            if (r_s2) begin
              r_valid <= 1'b1;
              r_state <= D_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= D_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        D_WAIT_HI: begin
          if (r_s2) r_state <= D_IDLE;
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

  assign byte_valid = r_valid;
  assign rx_byte    = r_shift;
  assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_io_unit.sv
// UART responder for the SENDB/RECVB handshake: 8N1 transmitter,
// buffered receiver and the request/complete control FSM.
module uart_io_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_go,
  input  logic       rors,
  input  logic [7:0] tx_data,
  output logic       uart_done,
  output logic [7:0] rx_data,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  ctl_state_t    r_state;
  logic [9:0]    r_frame;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic          r_done;
  logic [7:0]    r_rx_data;

  logic [7:0]    r_mem [RX_FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_ovr;
  logic          r_ferr;

  logic          w_valid;
  logic [7:0]    w_byte;
  logic          w_ferr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_valid(w_valid),
    .rx_byte   (w_byte),
    .frame_err (w_ferr)
  );

  // Extra pointer MSB separates full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = (r_state == C_RX_WAIT) && !w_empty;
  assign w_push  = w_valid && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_valid && w_full && !w_pop) r_ovr <= 1'b1;
      if (w_ferr) r_ferr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= C_IDLE;
      r_frame   <= '1;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        C_IDLE: begin
          if (uart_go) begin
            if (rors == RORS_SEND) begin
              r_frame <= {1'b1, tx_data, 1'b0};
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= C_TX_BIT;
            end else begin
              r_state <= C_RX_WAIT;
            end
          end
        end
        // Ones shift in behind the frame, so txd rests high afterwards
        C_TX_BIT: begin
          if (r_cnt == BIT_END) begin
            r_cnt   <= '0;
            r_frame <= {1'b1, r_frame[9:1]};
            if (r_bit == 4'd9) begin
              r_done  <= 1'b1;
              r_state <= C_TX_DONE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        C_TX_DONE: r_state <= C_IDLE;
        C_RX_WAIT: begin
          if (!w_empty) begin
            r_rx_data <= r_mem[r_rd_ptr[AW-1:0]];
            r_done    <= 1'b1;
            r_state   <= C_RX_DONE;
          end
        end
        C_RX_DONE: r_state <= C_IDLE;
        default:   r_state <= C_IDLE;
      endcase
    end
  end

  assign txd          = r_frame[0];
  assign uart_done    = r_done;
  assign rx_data      = r_rx_data;
  assign rx_overrun   = r_ovr;
  assign rx_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_io_unit.sv
// Directed bench for uart_io_unit at 4 clocks per bit.
// Frame timings and expected bytes are hand-derived constants.
module tb_uart_io_unit;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_go;
  logic       rors;
  logic [7:0] tx_data;
  logic       uart_done;
  logic [7:0] rx_data;
  logic       txd;
  logic       rxd;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  uart_io_unit #(
    .CLKS_PER_BIT (C),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_go     (uart_go),
    .rors        (rors),
    .tx_data     (tx_data),
    .uart_done   (uart_done),
    .rx_data     (rx_data),
    .txd         (txd),
    .rxd         (rxd),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic go(input logic r, input logic [7:0] d);
    rors    = r;
    tx_data = d;
    uart_go = 1'b1;
    tick();
    uart_go = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stopb);
    logic [9:0] f;
    f = {stopb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      ticks(C);
    end
  endtask

  // Entered at cycle g+1; checks every txd cycle and the done pulse
  task automatic check_tx(input string tag, input logic [7:0] d,
                          input int g, input int d0);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < C; j++) begin
        chk(tag, {31'd0, txd}, {31'd0, f[i]});
        tick();
      end
    end
    chk({tag, "_done"}, {31'd0, uart_done}, 32'd1);
    tick();
    chk({tag, "_ndone"}, done_cnt, d0 + 1);
    chk({tag, "_dcyc"}, done_cyc, g + 41);
  endtask

  int g;
  int k;
  int d0;

  initial begin
    rst     = 1'b1;
    uart_go = 1'b0;
    rors    = 1'b0;
    tx_data = 8'h00;
    rxd     = 1'b1;
    ticks(2);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_done", {31'd0, uart_done}, 32'd0);
    chk("rst_rxdata", {24'd0, rx_data}, 32'h00);
    chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // 1: send 0xA5
    g  = cyc;
    d0 = done_cnt;
    go(1'b1, 8'hA5);
    check_tx("tx_a5", 8'hA5, g, d0);

    // 2: byte buffered before the request
    frame(8'h3C, 1'b1);
    ticks(3);
    g  = cyc;
    d0 = done_cnt;
    go(1'b0, 8'h00);
    tick();
    chk("rx3c_done", {31'd0, uart_done}, 32'd1);
    chk("rx3c_data", {24'd0, rx_data}, 32'h3C);
    ticks(20);
    chk("rx3c_hold", {24'd0, rx_data}, 32'h3C);
    chk("rx3c_ndone", done_cnt, d0 + 1);

    // 3: request first, byte arrives later
    go(1'b0, 8'h00);
    ticks(3);
    k  = cyc;
    d0 = done_cnt;
    frame(8'h7E, 1'b1);
    ticks(5);
    chk("rx7e_ndone", done_cnt, d0 + 1);
    chk("rx7e_dcyc", done_cyc, k + 43);
    chk("rx7e_data", {24'd0, rx_data}, 32'h7E);

    // 4: overrun with depth 4
    for (int i = 1; i <= 5; i++) begin
      frame(8'(i), 1'b1);
      ticks(2);
      if (i == 4) chk("ovr_pre", {31'd0, rx_overrun}, 32'd0);
    end
    chk("ovr_set", {31'd0, rx_overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      go(1'b0, 8'h00);
      tick();
      chk("ovr_pop_done", {31'd0, uart_done}, 32'd1);
      chk("ovr_pop_data", {24'd0, rx_data}, i);
      tick();
    end
    d0 = done_cnt;
    go(1'b0, 8'h00);
    ticks(20);
    chk("ovr_5th_wait", done_cnt, d0);
    frame(8'h99, 1'b1);
    ticks(5);
    chk("ovr_5th_done", done_cnt, d0 + 1);
    chk("ovr_5th_data", {24'd0, rx_data}, 32'h99);

    // 5: glitch and bad stop bit never reach the FIFO
    d0 = done_cnt;
    go(1'b0, 8'h00);
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    ticks(50);
    chk("glitch_ndone", done_cnt, d0);
    chk("glitch_ferr", {31'd0, rx_frame_err}, 32'd0);
    frame(8'h55, 1'b0);
    rxd = 1'b1;
    ticks(10);
    chk("badstop_ferr", {31'd0, rx_frame_err}, 32'd1);
    chk("badstop_ndone", done_cnt, d0);
    frame(8'h42, 1'b1);
    ticks(5);
    chk("after_bad_done", done_cnt, d0 + 1);
    chk("after_bad_data", {24'd0, rx_data}, 32'h42);

    // 6a: go during a send is ignored
    g  = cyc;
    d0 = done_cnt;
    go(1'b1, 8'hFF);
    chk("ff_start", {31'd0, txd}, 32'd0);
    ticks(9);
    go(1'b1, 8'h00);
    ticks(9);
    chk("ff_bit4", {31'd0, txd}, 32'd1);
    ticks(21);
    chk("ff_done", {31'd0, uart_done}, 32'd1);
    tick();
    chk("ff_dcyc", done_cyc, g + 41);
    ticks(20);
    chk("ff_ndone", done_cnt, d0 + 1);

    // 6b: reset in the middle of a send
    go(1'b1, 8'hFF);
    ticks(21);
    rst = 1'b1;
    #1;
    chk("mrst_txd", {31'd0, txd}, 32'd1);
    chk("mrst_done", {31'd0, uart_done}, 32'd0);
    chk("mrst_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("mrst_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk("mrst_rxdata", {24'd0, rx_data}, 32'h00);
    d0 = done_cnt;
    ticks(2);
    rst = 1'b0;
    ticks(50);
    chk("mrst_ndone", done_cnt, d0);
    g  = cyc;
    d0 = done_cnt;
    go(1'b1, 8'h81);
    check_tx("tx_81", 8'h81, g, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_io_unit.md
Name: uart_io_unit

Overview:
Byte-level UART responder serving the core controller's SENDB/RECVB handshake.
- rors=1 with a uart_go pulse: serialises the register byte on txd in 8N1 format, then pulses uart_done.
- rors=0 with a uart_go pulse: returns the oldest received byte from a small RX FIFO, then pulses uart_done.
- The RX deserialiser runs continuously, so bytes arriving between RECVB instructions are buffered.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 4.
RX_FIFO_DEPTH, 4, RX buffer entries; power of two, >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
uart_go  in  1  single-cycle request pulse from controller
rors  in  1  request type, sampled with uart_go: 1 = send, 0 = receive
tx_data  in  8  byte to send, sampled with uart_go when rors=1
uart_done  out  1  single-cycle completion pulse
rx_data  out  8  received byte; held until the next receive completes
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous
rx_overrun  out  1  sticky: a byte was dropped because the FIFO was full
rx_frame_err  out  1  sticky: a stop bit was sampled low

Behaviour:
- Reset values: txd=1, uart_done=0, rx_data=0, rx_overrun=0, rx_frame_err=0.
- Reset state: FIFO empty, both FSMs IDLE, rxd synchroniser flops = 1.
- Reset mid-frame: txd goes high immediately and the partial frame is abandoned (TX or RX).
- Sticky flags clear only on reset.

Control FSM states: IDLE, TX_BIT, TX_DONE, RX_WAIT, RX_DONE.
- uart_go is honoured only in IDLE; a uart_go in any other state is ignored.
- IDLE + uart_go + rors=1:
  - latch tx_data into a 10-bit frame {1, data, 0}; go to TX_BIT.
  - txd is driven from the frame LSB starting the cycle after go.
  - frame shifts every CLKS_PER_BIT cycles; data bits go out LSB first.
  - after the 10th bit period go to TX_DONE.
- TX_DONE: uart_done=1 for one cycle, then IDLE.
  - go in cycle 0 → txd low in cycles 1..C, stop bit in cycles 9C+1..10C, uart_done in cycle 10C+1 (C = CLKS_PER_BIT).
- IDLE + uart_go + rors=0: go to RX_WAIT.
- RX_WAIT: when the FIFO is non-empty, pop the head into rx_data and go to RX_DONE.
  - FIFO already non-empty at go → uart_done in cycle go+2.
  - FIFO empty at go → waits indefinitely; there is no timeout.
- RX_DONE: uart_done=1 for one cycle, then IDLE.
  - rx_data is valid from the uart_done cycle and held until the next pop.
- txd is held at 1 in all non-TX states.

RX deserialiser, independent of the control FSM:
- rxd passes through a 2-FF synchroniser.
- Idle → on a sampled low, wait C/2 cycles and re-sample.
  - High at re-sample: false start, return to idle.
- Otherwise sample 8 data bits, LSB first, every C cycles at bit centres, then sample the stop bit.
- Stop bit = 1: push the byte.
- Stop bit = 0: discard the byte, set rx_frame_err, and wait for rxd high before re-arming.

FIFO:
- Pointers are log2(depth)+1 bits wide, for the full/empty distinction.
- Push while full without a simultaneous pop: byte dropped, rx_overrun set, contents unchanged.
- Push and pop in the same cycle: both succeed; this includes the full case, where count is unchanged.
- A pop never returns data in the same cycle it is pushed; a push into an empty FIFO becomes visible the next cycle.

Decomposition:
- Package uart_pkg:
  - rors encodings RORS_SEND=1'b1, RORS_RECV=1'b0
  - control and deserialiser state enums
  - default CLKS_PER_BIT constant
- One sub-module, uart_rx_deser: synchroniser, bit timing and framing check.
  - Outputs: byte_valid pulse, byte[7:0], frame_err pulse.
- FIFO, TX shifter and control FSM stay in uart_io_unit.

Test Plan:
All scenarios run with CLKS_PER_BIT=4.
1. uart_go, rors=1, tx_data=0xA5 at cycle 0 → txd bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles from cycle 1; uart_done high only in cycle 41.
2. Serial frame 0x3C on rxd; afterwards uart_go, rors=0 → uart_done two cycles after go; rx_data=0x3C, held through 20 further idle cycles.
3. uart_go, rors=0 with FIFO empty, then frame 0x7E on rxd → uart_done never before the push; asserted exactly 2 cycles after the push; rx_data=0x7E.
4. Five frames 0x01..0x05 with depth 4, no pops → rx_overrun=1; five receive requests return 01, 02, 03, 04; the fifth stays in RX_WAIT with no uart_done.
5. rxd low pulse of one cycle → no push, no flags. Frame 0x55 with stop bit low → no push, rx_frame_err=1.
6. Send 0xFF, extra uart_go during bit 2 → ignored, single uart_done. rst asserted during bit 5 → txd=1 and uart_done=0 immediately; a post-reset send of 0x81 produces a complete correct frame.
